// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_wb_arbiter_pkg: shared widths, encodings and the writeback buffer entry type.
package regfile_wb_arbiter_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int NUM_REGS = 32;
  localparam logic [DATA_W-1:0] ZERO_WORD = '0;
  localparam logic RST_ENABLE = 1'b0;
  localparam logic WRITE_ENABLE = 1'b1;
  typedef struct packed {
    logic valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_wb_arbiter_squash_fifo.sv
// wb_squash_fifo: circular buffer of late writes with per-entry valid, address squash and pending mask.
module wb_squash_fifo import regfile_wb_arbiter_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic pop,
  input  logic squash,
  input  logic [ADDR_W-1:0] squash_addr,
  output logic head_valid,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic [CW-1:0] count,
  output logic [NUM_REGS-1:0] pend_mask
);
  wb_entry_t ent_q [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q, count_d;
  assign head_valid = ent_q[head_q].valid;
  assign head_addr = ent_q[head_q].addr;
  assign head_data = ent_q[head_q].data;
  assign count = count_q;
  assign count_d = count_q + CW'(push) - CW'(pop);
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_q[i].valid) pend_mask[ent_q[i].addr] = 1'b1;
  end
  // Push is written after the squash loop; the caller never pushes an address it is squashing.
  always_ff @(posedge clk or negedge rst)
    if (rst == RST_ENABLE) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (squash && ent_q[i].addr == squash_addr) ent_q[i].valid <= 1'b0;
      if (pop) ent_q[head_q].valid <= 1'b0;
      if (push) ent_q[tail_q] <= '{valid: 1'b1, addr: push_addr, data: push_data};
      head_q <= pop ? head_q + PW'(1) : head_q;
      tail_q <= push ? tail_q + PW'(1) : tail_q;
      count_q <= count_d;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: merges pipeline writeback and buffered multi-cycle results onto one register file write port.
module regfile_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic p_we,
  input  logic [ADDR_W-1:0] p_waddr,
  input  logic [DATA_W-1:0] p_wdata,
  input  logic a_valid,
  output logic a_ready,
  input  logic [ADDR_W-1:0] a_waddr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic [31:0] pend_mask,
  output logic stall_req
);
  import regfile_wb_arbiter_pkg::*;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic p_eff, push, pop, drain, head_valid;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [CW-1:0] count;
  logic we_d, we_q, stall_d, stall_q;
  logic [ADDR_W-1:0] waddr_d, waddr_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;
  logic [SW-1:0] starve_d, starve_q;
  assign p_eff = p_we == WRITE_ENABLE && p_waddr != '0;
  assign a_ready = rst != RST_ENABLE && count < CW'(DEPTH);
  // A same-cycle transfer to the register the pipeline writes is older, so it is accepted and dropped.
  assign push = a_valid && a_ready && a_waddr != '0 && !(p_eff && a_waddr == p_waddr);
  assign pop = !p_eff && count != '0;
  assign drain = pop && head_valid;
  wb_squash_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .push_addr(a_waddr),
    .push_data(a_wdata),
    .pop(pop),
    .squash(p_eff),
    .squash_addr(p_waddr),
    .head_valid(head_valid),
    .head_addr(head_addr),
    .head_data(head_data),
    .count(count),
    .pend_mask(pend_mask)
  );
  always_comb begin
    we_d = p_eff || drain;
    waddr_d = p_eff ? p_waddr : drain ? head_addr : waddr_q;
    wdata_d = p_eff ? p_wdata : drain ? head_data : wdata_q;
    starve_d = (pop || count == '0) ? '0
             : (head_valid && starve_q != SW'(STARVE_LIMIT)) ? starve_q + SW'(1) : starve_q;
    stall_d = starve_d == SW'(STARVE_LIMIT);
  end
  always_ff @(posedge clk or negedge rst)
    if (rst == RST_ENABLE) begin
      we_q <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      starve_q <= '0;
      stall_q <= 1'b0;
    end else begin
      we_q <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      starve_q <= starve_d;
      stall_q <= stall_d;
    end
  assign we = we_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign stall_req = stall_q;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed self-checking bench for the register file writeback arbiter.
module tb_regfile_wb_arbiter;
  logic clk, rst, p_we, a_valid, a_ready, we, stall_req;
  logic [4:0] p_waddr, a_waddr, waddr;
  logic [31:0] p_wdata, a_wdata, wdata, pend_mask;
  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8), .ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .p_we(p_we), .p_waddr(p_waddr), .p_wdata(p_wdata),
    .a_valid(a_valid), .a_ready(a_ready), .a_waddr(a_waddr), .a_wdata(a_wdata),
    .we(we), .waddr(waddr), .wdata(wdata),
    .pend_mask(pend_mask), .stall_req(stall_req)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic outw(input string tag, input logic ew, input logic [4:0] ea, input logic [31:0] ed);
    chk({tag, ".we"}, 32'(we), 32'(ew));
    chk({tag, ".waddr"}, 32'(waddr), 32'(ea));
    chk({tag, ".wdata"}, wdata, ed);
  endtask

  task automatic drive(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                       input logic av, input logic [4:0] aa, input logic [31:0] ad);
    p_we = pwe; p_waddr = pa; p_wdata = pd;
    a_valid = av; a_waddr = aa; a_wdata = ad;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    outw("rst", 0, 0, 0);
    chk("rst.pend", pend_mask, 0);
    chk("rst.ready", 32'(a_ready), 0);
    chk("rst.stall", 32'(stall_req), 0);
    tick();
    #2 rst = 1'b1;
    tick();
    chk("idle.ready", 32'(a_ready), 1);
    chk("idle.we", 32'(we), 0);

    drive(1, 0, 32'hFF, 1, 0, 32'h33);
    tick();
    outw("zero", 0, 0, 0);
    chk("zero.pend", pend_mask, 0);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    outw("zero2", 0, 0, 0);
    chk("zero2.ready", 32'(a_ready), 1);

    drive(1, 5, 32'h11, 1, 7, 32'h22);
    tick();
    outw("pri0", 1, 5, 32'h11);
    chk("pri0.pend", pend_mask, 32'h80);
    drive(1, 5, 32'h11, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      outw("pri", 1, 5, 32'h11);
      chk("pri.pend", pend_mask, 32'h80);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    outw("pri.drain", 1, 7, 32'h22);
    chk("pri.pend_clr", pend_mask, 0);
    tick();
    outw("pri.idle", 0, 7, 32'h22);

    drive(0, 0, 0, 1, 9, 32'hAA);
    tick();
    outw("waw.enq", 0, 7, 32'h22);
    chk("waw.pend", pend_mask, 32'h200);
    drive(1, 9, 32'hBB, 0, 0, 0);
    tick();
    outw("waw.p", 1, 9, 32'hBB);
    chk("waw.pend_clr", pend_mask, 0);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    outw("waw.silent", 0, 9, 32'hBB);
    tick();
    outw("waw.idle", 0, 9, 32'hBB);
    chk("waw.ready", 32'(a_ready), 1);

    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 32'h5, 1, 5'(10 + i), 32'hD0 + 32'(i));
      tick();
      outw("full.p", 1, 1, 32'h5);
    end
    chk("full.ready", 32'(a_ready), 0);
    chk("full.pend", pend_mask, 32'h3C00);
    drive(1, 1, 32'h5, 1, 14, 32'hEE);
    tick();
    outw("full.p5", 1, 1, 32'h5);
    chk("full.ready5", 32'(a_ready), 0);
    chk("full.pend5", pend_mask, 32'h3C00);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      outw("full.drain", 1, 5'(10 + i), 32'hD0 + 32'(i));
    end
    chk("full.ready_end", 32'(a_ready), 1);
    chk("full.pend_end", pend_mask, 0);
    chk("full.stall", 32'(stall_req), 0);
    tick();
    outw("full.idle", 0, 13, 32'hD3);

    drive(1, 2, 32'h77, 1, 20, 32'hCC);
    tick();
    outw("stv.enq", 1, 2, 32'h77);
    chk("stv.pend", pend_mask, 32'h0010_0000);
    chk("stv.stall0", 32'(stall_req), 0);
    drive(1, 2, 32'h77, 0, 0, 0);
    for (int k = 1; k < 8; k++) begin
      tick();
      chk("stv.wait", 32'(stall_req), 0);
    end
    tick();
    chk("stv.assert", 32'(stall_req), 1);
    tick();
    outw("stv.pwins", 1, 2, 32'h77);
    chk("stv.hold", 32'(stall_req), 1);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    outw("stv.drain", 1, 20, 32'hCC);
    chk("stv.release", 32'(stall_req), 0);
    chk("stv.pend_clr", pend_mask, 0);

    for (int i = 0; i < 3; i++) begin
      drive(1, 3, 32'h1, 1, 5'(15 + i), 32'h40 + 32'(i));
      tick();
    end
    chk("mid.pend", pend_mask, 32'h0003_8000);
    drive(0, 0, 0, 0, 0, 0);
    #2 rst = 1'b0;
    #1;
    outw("mid.rst", 0, 0, 0);
    chk("mid.pend_rst", pend_mask, 0);
    chk("mid.ready_rst", 32'(a_ready), 0);
    chk("mid.stall_rst", 32'(stall_req), 0);
    #2 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      outw("mid.after", 0, 0, 0);
      chk("mid.ready", 32'(a_ready), 1);
      chk("mid.pend", pend_mask, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Writer side of the 32x32 register file write port (we/waddr/wdata).
- Merges two write sources into the single port: in-order pipeline writeback (priority, no backpressure) and a multi-cycle unit (divider / late load) with valid/ready handshake.
- Buffers multi-cycle results, drops stale writes (WAW), and exports a pending-register mask and a stall request to decode/control.

Parameters:
DEPTH, 4, async-write buffer entries (power of two, >=2)
STARVE_LIMIT, 8, cycles a valid buffer head may wait before stall_req asserts
ADDR_W, 5, register address width
DATA_W, 32, register data width

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
p_we  in  1  pipeline writeback enable
p_waddr  in  ADDR_W  pipeline destination register
p_wdata  in  DATA_W  pipeline result
a_valid  in  1  multi-cycle unit result valid
a_ready  out  1  buffer can accept (transfer = a_valid & a_ready)
a_waddr  in  ADDR_W  multi-cycle destination register
a_wdata  in  DATA_W  multi-cycle result
we  out  1  register file write enable
waddr  out  ADDR_W  register file write address
wdata  out  DATA_W  register file write data
pend_mask  out  32  bit i = a valid buffered write to register i exists
stall_req  out  1  request pipeline to suppress p_we next cycle

Behaviour:
- Reset (rst=0, async): we=0, waddr=0, wdata=0, stall_req=0, all buffer entries invalid, head/tail/count=0, starve counter=0. While rst=0: a_ready=0, pend_mask=0.
- Outputs we/waddr/wdata are registered: one cycle from selected source to port.
- Effective pipeline write: p_we=1 and p_waddr!=0. If p_we=1 with p_waddr=0, it is ignored entirely (no output write, no squash).
- a_ready = (count < DEPTH), from registered count. When full, no enqueue, even if a dequeue occurs the same cycle.
- Enqueue: on a transfer with a_waddr!=0, write {valid=1, addr, data} at tail and advance tail. If a_waddr=0, the transfer is accepted and discarded.
- Priority: an effective pipeline write always wins. The next-cycle output is {1, p_waddr, p_wdata}.
- Drain: with no effective pipeline write and count>0:
  - valid head: output {1, head.addr, head.data} and pop.
  - invalid (squashed) head: pop silently; output we=0 next cycle.
  - one pop per cycle maximum.
- No write selected: we=0 next cycle; waddr/wdata hold their last values.
- WAW squash: an effective pipeline write to register r clears valid on every buffered entry with addr=r, same cycle. A transfer to r in that same cycle is treated as older: it is accepted but not enqueued.
- Simultaneous enqueue and pop: count unchanged; both pointers advance modulo DEPTH.
- pend_mask: combinational OR over valid entries of the one-hot of addr. It is updated in the cycle after an enqueue or squash takes effect. Bit 0 is never set.
- Starvation:
  - Counter increments each cycle the head is valid and not popped.
  - Clears on a pop or when the buffer is empty.
  - When the counter reaches STARVE_LIMIT, stall_req=1 (registered).
  - stall_req deasserts the cycle after the head pops.
- Pipeline contract: it honours stall_req by holding p_we=0 one cycle later. A p_we arriving despite stall_req still wins.

Decomposition:
- Shared package constants: ADDR_W, DATA_W, register count 32, ZeroWord, RstEnable (active-low) and WriteEnable encodings.
- Shared package typedef: the buffer entry struct {valid, addr, data}.
- Natural sub-module: wb_squash_fifo (DEPTH-entry circular buffer with per-entry valid, address-match squash, and pend_mask generation).
- The top level holds arbitration, starvation counter, and output registers.

Test Plan:
- Reset mid-drain: 3 entries queued, rst=0 mid-cycle -> we=0 and pend_mask=0 immediately; a_ready=1 after release; no write of queued data ever appears.
- Priority: p_we=1 r5=0x11 every cycle for 4 cycles while a_valid r7=0x22 transferred -> outputs r5 x4, then r7=0x22 on the 5th cycle after p_we drops; pend_mask bit7 is 1 in between.
- WAW squash: enqueue r9=0xAA, then p_we r9=0xBB -> output r9=0xBB only; head popped silently with we=0; pend_mask bit9 clears the next cycle.
- Full buffer: 4 transfers with p_we held high -> a_ready=0 after the 4th; a 5th a_valid is not accepted; after p_we drops, 4 writes drain in FIFO order, then a_ready=1.
- Starvation: one entry queued, p_we held high -> stall_req=1 exactly STARVE_LIMIT=8 cycles after enqueue; bench drops p_we -> entry writes, stall_req=0 the following cycle.
- Zero-register handling: p_we r0=0xFF and transfer a_waddr=0 -> no output write, count stays 0, pend_mask=0.
